linescanner_sensor_emulator: RTL and testbench



---
 rtl/linescanner_sensor_emulator.sv | 172 +++++++++++++++++
 tb/tb_linescanner_sensor_emulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/linescanner_sensor_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : linescanner_sensor_emulator
//  Purpose  : Synthesizable stand-in for the line-scan sensor. It watches the
//             exposure controls (rst_cvc, rst_cds, sample), accepts a
//             transfer/convert request (load_pulse), holds end_adc low for a
//             fixed conversion time and then streams one line of NUM_PIXELS
//             pixels with lval high. Pixel content is a deterministic ramp
//             (pixel_index + line_index) for exposed lines, DARK_LEVEL otherwise.
//  Ports    : pixel_clock    - sole clock, rising edge
//             reset          - synchronous, active-high
//             rst_cvc/rst_cds- sensor resets, low = exposure window open
//             sample         - sample strobe; its falling edge ends an exposure
//             load_pulse     - one-cycle transfer/convert request
//             end_adc        - 1 = ADC idle, 0 = conversion running
//             lval           - line valid, NUM_PIXELS cycles per line
//             data[7:0]      - pixel data while lval=1, else 8'h00
//             protocol_error - sticky misuse flag (checker build only)
//  Options  : LINESCANNER_EMU_PROTOCOL_CHECK_EN - when defined, builds the
//             protocol checker driving protocol_error; otherwise tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module linescanner_sensor_emulator #(
    parameter int unsigned NUM_PIXELS = 16,
    parameter int unsigned ADC_CLOCKS = 40,
    parameter logic [7:0]  DARK_LEVEL = 8'h10
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic       rst_cvc,
    input  logic       rst_cds,
    input  logic       sample,
    input  logic       load_pulse,
    output logic       end_adc,
    output logic       lval,
    output logic [7:0] data,
    output logic       protocol_error
);

    localparam logic [11:0] c_PIX_LAST = 12'(NUM_PIXELS - 1);
    localparam logic [15:0] c_ADC_LAST = 16'(ADC_CLOCKS - 1);

    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_CONVERT = 2'd1,
        ST_READOUT = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  line_index_q;
    logic [11:0] pixel_index_q;
    logic [15:0] adc_count_q;
    logic        exposure_done_q;
    logic        line_exposed_q;
    logic        sample_q;
    logic        end_adc_q;
    logic        lval_q;
    logic [7:0]  data_q;

    logic        w_expose_fall;
    logic [11:0] w_pixel_inc;

    // An exposure only counts when both sensor resets are released in the
    // very cycle the sample strobe falls.
    assign w_expose_fall = sample_q & ~sample & ~rst_cvc & ~rst_cds;
    assign w_pixel_inc   = pixel_index_q + 12'd1;

    function automatic logic [7:0] f_pixel(input logic        exposed,
                                           input logic [11:0] pix,
                                           input logic [7:0]  line);
        f_pixel = exposed ? (pix[7:0] + line) : DARK_LEVEL;
    endfunction

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state_q         <= ST_READY;
            line_index_q    <= 8'd0;
            pixel_index_q   <= 12'd0;
            adc_count_q     <= 16'd0;
            exposure_done_q <= 1'b0;
            line_exposed_q  <= 1'b0;
            sample_q        <= 1'b0;
            end_adc_q       <= 1'b1;
            lval_q          <= 1'b0;
            data_q          <= 8'h00;
        end else begin
            sample_q <= sample;
            // Exposures seen in any state are held for the next accepted load.
            if (w_expose_fall) begin
                exposure_done_q <= 1'b1;
            end

            case (state_q)
                ST_READY: begin
                    end_adc_q <= 1'b1;
                    lval_q    <= 1'b0;
                    data_q    <= 8'h00;
                    if (load_pulse) begin
                        state_q         <= ST_CONVERT;
                        end_adc_q       <= 1'b0;
                        // A falling edge coinciding with the load belongs to
                        // this line; the clear below overrides the set above.
                        line_exposed_q  <= exposure_done_q | w_expose_fall;
                        exposure_done_q <= 1'b0;
                        adc_count_q     <= 16'd0;
                    end
                end

                ST_CONVERT: begin
                    if (adc_count_q == c_ADC_LAST) begin
                        state_q       <= ST_READOUT;
                        end_adc_q     <= 1'b1;
                        lval_q        <= 1'b1;
                        pixel_index_q <= 12'd0;
                        data_q        <= f_pixel(line_exposed_q, 12'd0, line_index_q);
                    end else begin
                        adc_count_q <= adc_count_q + 16'd1;
                    end
                end

                ST_READOUT: begin
                    // pixel_index_q tracks the pixel currently on data_q.
                    if (pixel_index_q == c_PIX_LAST) begin
                        state_q      <= ST_READY;
                        lval_q       <= 1'b0;
                        data_q       <= 8'h00;
                        line_index_q <= line_index_q + 8'd1;
                    end else begin
                        pixel_index_q <= w_pixel_inc;
                        data_q        <= f_pixel(line_exposed_q, w_pixel_inc, line_index_q);
                    end
                end

                default: begin
                    state_q   <= ST_READY;
                    end_adc_q <= 1'b1;
                    lval_q    <= 1'b0;
                    data_q    <= 8'h00;
                end
            endcase
        end
    end

    assign end_adc = end_adc_q;
    assign lval    = lval_q;
    assign data    = data_q;

`ifdef LINESCANNER_EMU_PROTOCOL_CHECK_EN
    logic protocol_error_q;
    logic w_sample_rise;
    logic w_violation;

    assign w_sample_rise = ~sample_q & sample;
    assign w_violation   = (load_pulse && (state_q != ST_READY))
                         || (w_sample_rise && !end_adc_q)
                         || (load_pulse && (state_q == ST_READY) && sample);

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            protocol_error_q <= 1'b0;
        end else if (w_violation) begin
            protocol_error_q <= 1'b1;
        end
    end

    assign protocol_error = protocol_error_q;
`else
    assign protocol_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_linescanner_sensor_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_linescanner_sensor_emulator
//  Purpose  : Directed self-checking bench for linescanner_sensor_emulator.
//             Inputs change and outputs are checked on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_linescanner_sensor_emulator;

    localparam int unsigned c_NPIX = 16;
    localparam int unsigned c_ADC  = 40;
    localparam logic [7:0]  c_DARK = 8'h10;
`ifdef LINESCANNER_EMU_PROTOCOL_CHECK_EN
    localparam bit c_CHK = 1'b1;
`else
    localparam bit c_CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rst_cvc = 1'b1;
    logic       rst_cds = 1'b1;
    logic       sample = 1'b0;
    logic       load_pulse = 1'b0;
    logic       end_adc;
    logic       lval;
    logic [7:0] data;
    logic       protocol_error;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_line = 8'd0;
    logic       exp_pe = 1'b0;

    always #5 clk = ~clk;

    linescanner_sensor_emulator #(
        .NUM_PIXELS (c_NPIX),
        .ADC_CLOCKS (c_ADC),
        .DARK_LEVEL (c_DARK)
    ) dut (
        .pixel_clock    (clk),
        .reset          (reset),
        .rst_cvc        (rst_cvc),
        .rst_cds        (rst_cds),
        .sample         (sample),
        .load_pulse     (load_pulse),
        .end_adc        (end_adc),
        .lval           (lval),
        .data           (data),
        .protocol_error (protocol_error)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    // Sample strobe 1->0 with the given sensor reset levels, in READY.
    task automatic expose(input logic cvc, input logic cds);
        rst_cvc = cvc;
        rst_cds = cds;
        sample  = 1'b1;
        tick();
        sample  = 1'b0;
        tick();
        rst_cvc = 1'b1;
        rst_cds = 1'b1;
        tick();
    endtask

    // One full line from READY. Observation k is the k-th falling edge after
    // the rising edge that accepts load_pulse.
    task automatic do_line(input string tag, input bit exposed,
                           input int inj_a, input int inj_b,
                           input bit mid_exp, input bit fall_at_load);
        logic       e_eadc;
        logic       e_lval;
        logic [7:0] e_data;
        logic [7:0] pix;
        if (fall_at_load) begin
            rst_cvc = 1'b0;
            rst_cds = 1'b0;
            sample  = 1'b1;
            tick();
            sample  = 1'b0;
        end
        load_pulse = 1'b1;
        tick();
        load_pulse = 1'b0;
        rst_cvc    = 1'b1;
        rst_cds    = 1'b1;
        for (int k = 1; k <= 57; k++) begin
            e_eadc = (k > int'(c_ADC));
            e_lval = (k >= 41) && (k <= 56);
            pix    = 8'(k - 41);
            e_data = !e_lval ? 8'h00 : (exposed ? pix + exp_line : c_DARK);
            n_cmp++;
            if (end_adc !== e_eadc) begin
                n_err++;
                $display("FAIL %s end_adc obs %0d: got %b want %b", tag, k, end_adc, e_eadc);
            end
            n_cmp++;
            if (lval !== e_lval) begin
                n_err++;
                $display("FAIL %s lval obs %0d: got %b want %b", tag, k, lval, e_lval);
            end
            n_cmp++;
            if (data !== e_data) begin
                n_err++;
                $display("FAIL %s data obs %0d: got %h want %h", tag, k, data, e_data);
            end
            n_cmp++;
            if (protocol_error !== exp_pe) begin
                n_err++;
                $display("FAIL %s protocol_error obs %0d: got %b want %b", tag, k, protocol_error, exp_pe);
            end
            load_pulse = (k == inj_a) || (k == inj_b);
            if (load_pulse && c_CHK) exp_pe = 1'b1;
            if (mid_exp) begin
                if (k == 45) begin rst_cvc = 1'b0; rst_cds = 1'b0; sample = 1'b1; end
                if (k == 46) sample = 1'b0;
                if (k == 47) begin rst_cvc = 1'b1; rst_cds = 1'b1; end
            end
            if (k < 57) tick();
        end
        load_pulse = 1'b0;
        exp_line   = exp_line + 8'd1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({end_adc, lval, data, protocol_error} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got eadc=%b lval=%b data=%h pe=%b want 1 0 00 0",
                     end_adc, lval, data, protocol_error);
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_cmp++;
            if ({end_adc, lval, data, protocol_error} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
                n_err++;
                $display("FAIL idle cycle %0d: got eadc=%b lval=%b data=%h pe=%b want 1 0 00 0",
                         i, end_adc, lval, data, protocol_error);
            end
        end
    endtask

    task automatic test_exposed_line;
        expose(1'b0, 1'b0);
        do_line("exposed_line0", 1'b1, 0, 0, 1'b0, 1'b0);
        expose(1'b0, 1'b0);
        do_line("exposed_line1", 1'b1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_dark_line;
        expose(1'b1, 1'b0);
        do_line("dark_cvc_high", 1'b0, 0, 0, 1'b0, 1'b0);
        expose(1'b0, 1'b1);
        do_line("dark_cds_high", 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_coincident_edge;
        do_line("coincident_load", 1'b1, 0, 0, 1'b0, 1'b1);
        do_line("after_coincident", 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_exposure_during_readout;
        do_line("readout_exposure_dark", 1'b0, 0, 0, 1'b1, 1'b0);
        do_line("readout_exposure_next", 1'b1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_load_ignored;
        expose(1'b0, 1'b0);
        do_line("load_ignored", 1'b1, 10, 48, 1'b0, 1'b0);
        do_line("after_ignored", 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 257; i++) begin
            expose(1'b0, 1'b0);
            do_line($sformatf("b2b_line%0d", exp_line), 1'b1, 0, 0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_midline;
        logic [7:0] e_data;
        expose(1'b0, 1'b0);
        load_pulse = 1'b1;
        tick();
        load_pulse = 1'b0;
        for (int k = 1; k < 46; k++) begin
            // Exposure inside readout that the reset must discard.
            if (k == 42) begin rst_cvc = 1'b0; rst_cds = 1'b0; sample = 1'b1; end
            if (k == 43) sample = 1'b0;
            if (k == 44) begin rst_cvc = 1'b1; rst_cds = 1'b1; end
            tick();
        end
        e_data = 8'd5 + exp_line;
        n_cmp++;
        if ({lval, data} !== {1'b1, e_data}) begin
            n_err++;
            $display("FAIL midline_pixel5: got lval=%b data=%h want 1 %h", lval, data, e_data);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({end_adc, lval, data, protocol_error} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL midline_reset: got eadc=%b lval=%b data=%h pe=%b want 1 0 00 0",
                     end_adc, lval, data, protocol_error);
        end
        reset    = 1'b0;
        exp_line = 8'd0;
        exp_pe   = 1'b0;
        do_line("after_reset_dark", 1'b0, 0, 0, 1'b0, 1'b0);
        // Line counter restarted at 0, so the next exposed line is 01..10.
        expose(1'b0, 1'b0);
        do_line("after_reset_exposed", 1'b1, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        tick();
        test_reset();
        test_exposed_line();
        test_dark_line();
        test_coincident_edge();
        test_exposure_during_readout();
        test_load_ignored();
        test_back_to_back();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
